ce_gen_multi: RTL and testbench

- Parametrised multi-channel clock-enable generator for the core's `clk_sys` domain.
- Replaces the single hard-coded pixel-enable counter with NUM_CH independent dividers. Typical channels: pixel enable, CPU overclock enable, ACIA baud enable, PS/2 sampling.
- Adds glitch-free runtime divisor changes, per-channel enable, a half-period phase pulse, and a global phase-realign request.
- Sits between the status/menu decode and the machine core; the video mixer and CPU consume its `ce` outputs.

---
 rtl/ce_gen_pkg.sv | 13 +
 rtl/ce_gen_channel.sv | 54 +++++
 rtl/ce_gen_multi.sv | 44 ++++
 tb/tb_ce_gen_multi.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ce_gen_pkg.sv
// Shared constants for the clock-enable generator: default divisor width and the
// standard divisors used by the core's pixel-enable channel.
package ce_gen_pkg;

    localparam int DIV_W_DEFAULT = 8;

    // Pixel enable terminal counts for the low- and high-resolution video modes.
    localparam int CE_PIX_LO = 11;
    localparam int CE_PIX_HI = 5;

    typedef logic [DIV_W_DEFAULT-1:0] div_default_t;

endpackage

// File: rtl/ce_gen_channel.sv
// One clock-enable divider. The divisor is shadowed and only reloaded at a wrap,
// so a runtime change never produces a runt or stretched period.
module ce_gen_channel
    import ce_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic [DIV_W-1:0] div,
    output logic             ce,
    output logic             ce_half,
    output logic [DIV_W-1:0] div_active
);

    typedef logic [DIV_W-1:0] div_t;

    div_t cnt;
    div_t div_s;
    logic wrap;
    logic half;

    always_comb begin
        wrap = (cnt == div_s);
        // A zero divisor wraps every cycle, so it has no meaningful midpoint.
        half = (cnt == (div_s >> 1)) && (div_s != '0);
    end

    // Reset, realign and disable all park the channel at the start of a period
    // with the current divisor loaded, so they share one branch.
    always_ff @(posedge clk_sys) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset || sync || !en) begin
            cnt     <= '0;
            div_s   <= div;
            ce      <= 1'b0;
            ce_half <= 1'b0;
        end else begin
            ce      <= wrap;
            ce_half <= half;
            if (wrap) begin
                cnt   <= '0;
                div_s <= div;
            end else begin
                cnt <= cnt + div_t'(1);
            end
        end
    end

    assign div_active = div_s;

endmodule

// File: rtl/ce_gen_multi.sv
// Multi-channel clock-enable generator: NUM_CH independent dividers sharing a
// global phase-realign request, with a registered acknowledge.
module ce_gen_multi
    import ce_gen_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = DIV_W_DEFAULT
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [NUM_CH*DIV_W-1:0] div,
    input  logic [NUM_CH-1:0]       en,
    input  logic                    sync_req,
    output logic [NUM_CH-1:0]       ce,
    output logic [NUM_CH-1:0]       ce_half,
    output logic [NUM_CH*DIV_W-1:0] div_active,
    output logic                    sync_ack
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ce_gen_channel #(
            .DIV_W(DIV_W)
        ) u_channel (
            .clk_sys    (clk_sys),
            .reset      (reset),
            .en         (en[i]),
            .sync       (sync_req),
            .div        (div[i*DIV_W +: DIV_W]),
            .ce         (ce[i]),
            .ce_half    (ce_half[i]),
            .div_active (div_active[i*DIV_W +: DIV_W])
        );
    end

    // The realign lands on the edge that samples sync_req; acknowledge one cycle later.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync_ack <= 1'b0;
        end else begin
            sync_ack <= sync_req;
        end
    end

endmodule

// File: tb/tb_ce_gen_multi.sv
// Bench for ce_gen_multi: a period-timestamp model checked every cycle, plus
// hand-computed expectations for each directed scenario.
module tb_ce_gen_multi;
    import ce_gen_pkg::*;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 8;

    logic                    clk_sys = 1'b0;
    logic                    reset;
    logic [NUM_CH*DIV_W-1:0] div;
    logic [NUM_CH-1:0]       en;
    logic                    sync_req;
    logic [NUM_CH-1:0]       ce;
    logic [NUM_CH-1:0]       ce_half;
    logic [NUM_CH*DIV_W-1:0] div_active;
    logic                    sync_ack;

    ce_gen_multi #(
        .NUM_CH(NUM_CH),
        .DIV_W (DIV_W)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .div        (div),
        .en         (en),
        .sync_req   (sync_req),
        .ce         (ce),
        .ce_half    (ce_half),
        .div_active (div_active),
        .sync_ack   (sync_ack)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (t=%0d, time %0t): actual=%0h required=%0h", name, t, $time, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_sys);
        t++;
    endtask

    task automatic set_div(input int ch, input int val);
        div[ch*DIV_W +: DIV_W] = DIV_W'(val);
    endtask

    // Model: each channel remembers the cycle its current period started and the
    // divisor in force; a pulse is due when the elapsed cycles equal the divisor.
    int                      cyc = 0;
    int                      start [NUM_CH];
    int                      dact  [NUM_CH];
    int                      phase;
    bit                      mvalid = 1'b0;
    logic [NUM_CH-1:0]       m_ce   = '0;
    logic [NUM_CH-1:0]       m_half = '0;
    logic                    m_ack  = 1'b0;
    logic [NUM_CH*DIV_W-1:0] m_dact = '0;

    initial begin
        forever begin
            @(posedge clk_sys);
            if (reset) begin
                mvalid = 1'b1;
                m_ack  = 1'b0;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    start[ch]  = cyc + 1;
                    dact[ch]   = int'(div[ch*DIV_W +: DIV_W]);
                    m_ce[ch]   = 1'b0;
                    m_half[ch] = 1'b0;
                end
            end else if (mvalid) begin
                m_ack = sync_req;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (sync_req || !en[ch]) begin
                        start[ch]  = cyc + 1;
                        dact[ch]   = int'(div[ch*DIV_W +: DIV_W]);
                        m_ce[ch]   = 1'b0;
                        m_half[ch] = 1'b0;
                    end else begin
                        phase      = cyc - start[ch];
                        m_ce[ch]   = (phase == dact[ch]);
                        m_half[ch] = (dact[ch] != 0) && (phase == dact[ch] / 2);
                        if (phase == dact[ch]) begin
                            start[ch] = cyc + 1;
                            dact[ch]  = int'(div[ch*DIV_W +: DIV_W]);
                        end
                    end
                end
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_dact[ch*DIV_W +: DIV_W] = DIV_W'(dact[ch]);
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            @(posedge clk_sys);
            #2;
            if (mvalid) begin
                check("model_ce",         ce,         m_ce);
                check("model_ce_half",    ce_half,    m_half);
                check("model_div_active", div_active, m_dact);
                check("model_sync_ack",   sync_ack,   m_ack);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        sync_req = 1'b0;
        en       = 4'b1111;
        div      = '0;
        set_div(0, CE_PIX_HI);
        set_div(1, 0);
        set_div(2, 3);
        set_div(3, CE_PIX_LO);
        repeat (3) step();
        check("reset_ce",       ce,       4'b0000);
        check("reset_ce_half",  ce_half,  4'b0000);
        check("reset_sync_ack", sync_ack, 1'b0);
        check("reset_div0",     div_active[0 +: DIV_W], 5);
        reset = 1'b0;
        t = 0;

        // D=5 on channel 0 (first pulse 6 cycles after release), D=0 on channel 1.
        for (int s = 1; s <= 13; s++) begin
            step();
            check("t1_ce0",      ce[0],      (s == 6) || (s == 12));
            check("t1_half0",    ce_half[0], (s == 3) || (s == 9));
            check("t1_div0",     div_active[0 +: DIV_W], 5);
            check("t1_ce1_d0",   ce[1],      1'b1);
            check("t1_half1_d0", ce_half[1], 1'b0);
        end

        // Mid-period divisor changes: channel 0 to 11, channel 1 to 1.
        step();
        set_div(0, CE_PIX_LO);
        set_div(1, 1);
        for (int s = 15; s <= 43; s++) begin
            step();
            check("t2_ce0",   ce[0],      (s == 18) || (s == 30) || (s == 42));
            check("t2_half0", ce_half[0], (s == 15) || (s == 24) || (s == 36));
            check("t2_div0",  div_active[0 +: DIV_W], (s < 18) ? 5 : 11);
            check("t3_ce1",   ce[1],      (s % 2) == 1);
            check("t3_half1", ce_half[1], (s % 2) == 0);
            check("t3_div1",  div_active[DIV_W +: DIV_W], 1);
        end

        // Channel 2 (D=3) disabled for 7 cycles mid-period.
        step();
        step();
        en[2] = 1'b0;
        for (int s = 46; s <= 52; s++) begin
            step();
            check("t4_ce2_off",   ce[2],      1'b0);
            check("t4_half2_off", ce_half[2], 1'b0);
        end
        en[2] = 1'b1;
        for (int s = 53; s <= 60; s++) begin
            step();
            check("t4_ce2",   ce[2],      (s == 56) || (s == 60));
            check("t4_half2", ce_half[2], (s == 54) || (s == 58));
        end

        // D=11 and D=5 at unrelated phases, then realign.
        set_div(1, CE_PIX_HI);
        repeat (7) step();
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        check("t5_ack",     sync_ack, 1'b1);
        check("t5_ce_sync", ce,       4'b0000);
        for (int off = 2; off <= 27; off++) begin
            step();
            check("t5_ack_low", sync_ack, 1'b0);
            check("t5_ce0",     ce[0],    (off == 13) || (off == 25));
            check("t5_ce1",     ce[1],    (off >= 7) && ((off % 6) == 1));
        end

        // Realign channel 0 to D=5, then reset plus sync_req when cnt reaches 4.
        set_div(0, CE_PIX_HI);
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        check("t6_ack", sync_ack, 1'b1);
        repeat (4) step();
        reset    = 1'b1;
        sync_req = 1'b1;
        step();
        reset    = 1'b0;
        sync_req = 1'b0;
        check("t6_ce_rst",   ce,       4'b0000);
        check("t6_half_rst", ce_half,  4'b0000);
        check("t6_no_ack",   sync_ack, 1'b0);
        check("t6_div0",     div_active[0 +: DIV_W], 5);
        for (int off = 1; off <= 7; off++) begin
            step();
            check("t6_ce0",   ce[0],      off == 6);
            check("t6_half0", ce_half[0], off == 3);
            check("t6_ack0",  sync_ack,   1'b0);
        end

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
